// File: rtl/fetch_branch_unit_if.sv
// Fetch/branch unit bus: memory port, IR/decoder hand-off, controller handshake and status.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_branch_unit_if #(
  parameter int unsigned PC_W = 9
);
  logic [15:0]     mem_rdata;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic [15:0]     ir_out;
  logic            ir_valid;
  logic            exec_done;
  logic [2:0]      cond;
  logic [15:0]     sximm8;
  logic            N;
  logic            V;
  logic            Z;
  logic [PC_W-1:0] pc;
  logic            halted;
`ifdef FETCH_PERF_EN
  logic [15:0]     instr_count;
  logic [15:0]     taken_count;
`endif

  modport master (
    input  mem_rdata, exec_done, cond, sximm8, N, V, Z,
`ifdef FETCH_PERF_EN
    output instr_count, taken_count,
`endif
    output mem_addr, mem_rd, ir_out, ir_valid, pc, halted
  );

  modport slave (
    output mem_rdata, exec_done, cond, sximm8, N, V, Z,
`ifdef FETCH_PERF_EN
    input  instr_count, taken_count,
`endif
    input  mem_addr, mem_rd, ir_out, ir_valid, pc, halted
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// CPU front end: owns PC and IR, fetches from sync-read memory, resolves branches locally.
// Optional saturating perf counters (instr_count, taken_count) under FETCH_PERF_EN.
module fetch_branch_unit #(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_branch_unit_if.master  bus
);

  typedef enum logic [2:0] {StRst, StIf1, StIf2, StUpd, StExec, StHalt} state_e;

  localparam logic [2:0] OpBranch = 3'b001;
  localparam logic [2:0] OpHalt   = 3'b111;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            mem_rd_q, mem_rd_d;
  logic            halted_q, halted_d;

  logic        is_branch, is_halt, taken, nv_lt;
  logic [15:0] br_target;

  assign is_branch = (ir_q[15:13] == OpBranch);
  assign is_halt   = (ir_q[15:13] == OpHalt);
  assign nv_lt     = bus.N ^ bus.V;
  // Full 16-bit add, truncated to PC_W below, so the wrap is modulo 2^PC_W.
  assign br_target = {{(16-PC_W){1'b0}}, pc_q} + bus.sximm8;

  always_comb begin
    taken = 1'b0;
    case (bus.cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = bus.Z;
      3'b010:  taken = ~bus.Z;
      3'b011:  taken = nv_lt;
      3'b100:  taken = nv_lt | bus.Z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    mem_rd_d   = 1'b0;
    halted_d   = halted_q;
    unique case (state_q)
      StRst: begin
        state_d  = StIf1;
        mem_rd_d = 1'b1;
      end
      StIf1: begin
        state_d  = StIf2;
        mem_rd_d = 1'b1;
      end
      StIf2: begin
        ir_d    = bus.mem_rdata;
        state_d = StUpd;
      end
      StUpd: begin
        pc_d       = pc_q + PC_W'(1);
        state_d    = StExec;
        ir_valid_d = ~(is_branch | is_halt);
      end
      StExec: begin
        if (is_branch) begin
          if (taken) pc_d = br_target[PC_W-1:0];
          state_d  = StIf1;
          mem_rd_d = 1'b1;
        end else if (is_halt) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else if (bus.exec_done) begin
          state_d  = StIf1;
          mem_rd_d = 1'b1;
        end else begin
          ir_valid_d = 1'b1;
        end
      end
      StHalt: begin
        halted_d = 1'b1;
      end
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRst;
      pc_q       <= PC_W'(RESET_PC);
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_rd_q   <= mem_rd_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.mem_addr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.ir_out   = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] instr_cnt_q, instr_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (state_q == StUpd && instr_cnt_q != 16'hFFFF) instr_cnt_d = instr_cnt_q + 16'd1;
    if (state_q == StExec && is_branch && taken && taken_cnt_q != 16'hFFFF) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt_q <= 16'h0000;
      taken_cnt_q <= 16'h0000;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.instr_count = instr_cnt_q;
  assign bus.taken_count = taken_cnt_q;
`endif

endmodule
